// File: rtl/inv_perm_table_pkg.sv
// Shared definitions for the inverse-permutation table and its neighbours:
// symbol width, table depth, symbol type and the load/serve state encoding.
package inv_perm_table_pkg;

    localparam int SYM_W  = 8;
    localparam int SYM_N  = 1 << SYM_W;
    localparam int SYM_CW = SYM_W + 1;

    typedef logic [SYM_W-1:0] sym_t;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_READY = 1'b1
    } ipt_state_e;

endpackage

// File: rtl/inv_perm_table_if.sv
// Load and lookup bundle of the inverse-permutation table.
// master: permutation source / decrypt datapath; slave: the table.
interface inv_perm_table_if
    import inv_perm_table_pkg::*;
#(
    parameter int W = SYM_W
);

    logic         load_valid;
    logic [W-1:0] load_data;
    logic         load_ready;
    logic         dup_err;
    logic         table_ready;
    logic         lk_valid;
    logic [W-1:0] lk_data;
    logic         res_valid;
    logic [W-1:0] res_data;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  dup_err,
        input  table_ready,
        output lk_valid,
        output lk_data,
        input  res_valid,
        input  res_data
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output dup_err,
        output table_ready,
        input  lk_valid,
        input  lk_data,
        output res_valid,
        output res_data
    );

endinterface

// File: rtl/inv_perm_ram.sv
// Simple dual-port N x W RAM, one write port and one synchronous read port.
// Ports: clk; i_we/i_waddr/i_wdata write; i_re/i_raddr read, o_rdata holds.
module inv_perm_ram #(
    parameter int W = 8,
    parameter int N = 256
) (
    input  logic         clk,
    input  logic         i_we,
    input  logic [W-1:0] i_waddr,
    input  logic [W-1:0] i_wdata,
    input  logic         i_re,
    input  logic [W-1:0] i_raddr,
    output logic [W-1:0] o_rdata
);

    logic [W-1:0] r_mem [N];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/inv_perm_table.sv
// Builds Pinv[v] = k from a stream of unique forward-permutation values,
// then serves 1-cycle lookups. Ports: clk, rst (async), clr (sync), bus.
module inv_perm_table
    import inv_perm_table_pkg::*;
#(
    parameter int W  = SYM_W,
    parameter int CW = W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    inv_perm_table_if.slave   bus
);

    localparam int N = 1 << W;

    ipt_state_e    r_state;
    ipt_state_e    w_state_nxt;
    logic [N-1:0]  r_written;
    logic [CW-1:0] r_cnt;
    logic          r_dup;
    logic          r_res_valid;
    logic          r_res_zero;

    logic          w_load_ready;
    logic          w_table_ready;
    logic          w_xfer;
    logic          w_hit;
    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_last;
    logic [W-1:0]  w_ram_q;

    assign w_xfer  = bus.load_valid && w_load_ready;
    assign w_hit   = r_written[bus.load_data];
    assign w_wr_en = w_xfer && !w_hit && !clr;
    assign w_last  = (r_cnt == CW'(N - 1));
    assign w_rd_en = bus.lk_valid && w_table_ready && !clr;

    always_comb begin
        w_state_nxt   = r_state;
        w_load_ready  = 1'b0;
        w_table_ready = 1'b0;
        unique case (r_state)
            ST_LOAD: begin
                w_load_ready = 1'b1;
                if (w_wr_en && w_last) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                w_table_ready = 1'b1;
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
        if (clr) begin
            w_state_nxt = ST_LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // cnt saturates at N because no writes happen once READY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_written <= '0;
            r_dup     <= 1'b0;
        end else if (clr) begin
            r_cnt     <= '0;
            r_written <= '0;
            r_dup     <= 1'b0;
        end else begin
            r_dup <= w_xfer && w_hit;
            if (w_wr_en) begin
                r_cnt                     <= r_cnt + 1'b1;
                r_written[bus.load_data] <= 1'b1;
            end
        end
    end

    // The RAM read register has no reset, so res_data is forced to zero
    // until the first lookup after a reset or clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_zero  <= 1'b1;
        end else if (clr) begin
            r_res_valid <= 1'b0;
            r_res_zero  <= 1'b1;
        end else begin
            r_res_valid <= w_rd_en;
            if (w_rd_en) begin
                r_res_zero <= 1'b0;
            end
        end
    end

    inv_perm_ram #(
        .W (W),
        .N (N)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (bus.load_data),
        .i_wdata (r_cnt[W-1:0]),
        .i_re    (w_rd_en),
        .i_raddr (bus.lk_data),
        .o_rdata (w_ram_q)
    );

    assign bus.load_ready  = w_load_ready;
    assign bus.table_ready = w_table_ready;
    assign bus.dup_err     = r_dup;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_data    = r_res_zero ? '0 : w_ram_q;

endmodule
